md_sched: RTL and testbench

- Issue and hazard controller for the HI/LO multiply-divide unit in the 5-stage MIPS pipeline.
- Sits between the E-stage control decode and the MD datapath.
- Decides when an MD op may start and tracks the busy latency.
- Generates the D-stage stall for MD-dependent instructions, suppresses issue of E-stage ops cancelled by exception flush, and counts stall cycles for performance reporting.

---
 rtl/md_sched_pkg.sv | 34 +++
 rtl/md_lat_cnt.sv | 26 ++
 rtl/md_sched.sv | 84 ++++++++
 tb/tb_md_sched.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/md_sched_pkg.sv
// Shared definitions for the HI/LO multiply-divide issue controller:
// op encodings, FSM states, default latencies and op classification.
package md_sched_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MADD  = 3'd5,
    MD_MTHI  = 3'd6,
    MD_MTLO  = 3'd7
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  localparam int unsigned MULT_LAT_DEF = 5;
  localparam int unsigned DIV_LAT_DEF  = 10;
  localparam int unsigned CNT_W_DEF    = 4;

  function automatic logic md_is_long(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) ||
           (op == MD_DIVU) || (op == MD_MADD);
  endfunction

  function automatic logic md_is_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_lat_cnt.sv
// Loadable down-counter that parks at zero; o_done marks the final count.
module md_lat_cnt #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_done
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_done = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/md_sched.sv
// Issue/hazard controller for the HI/LO multiply-divide unit: starts MD ops
// from E, tracks busy latency, stalls dependent D-stage ops, counts stalls.
module md_sched
  import md_sched_pkg::*;
#(
  parameter int unsigned MULT_LAT      = MULT_LAT_DEF,
  parameter int unsigned DIV_LAT       = DIV_LAT_DEF,
  parameter int unsigned CNT_W         = CNT_W_DEF,
  parameter logic [31:0] STALL_CNT_RST = '0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        e_valid,
  input  logic [2:0]  e_md_op,
  input  logic        flush,
  input  logic        d_uses_md,
  output logic        md_start,
  output logic [2:0]  md_op,
  output logic        md_wr_hi,
  output logic        md_wr_lo,
  output logic        busy,
  output logic        stall_d,
  output logic        md_done,
  output logic        illegal_issue,
  output logic [31:0] stall_cnt
);

  md_state_e        r_state;
  logic [31:0]      r_stall_cnt;
  logic             w_iss;
  logic             w_idle;
  logic             w_idle_iss;
  logic             w_done;
  logic [CNT_W-1:0] w_load_val;

  assign w_iss      = e_valid && !flush;
  assign w_idle     = (r_state == ST_IDLE);
  assign w_idle_iss = w_idle && w_iss;

  // Strobes must land in the same cycle as the E operands, so they are
  // decoded from E directly rather than registered.
  assign md_start      = w_idle_iss && md_is_long(e_md_op);
  assign md_wr_hi      = w_idle_iss && (e_md_op == MD_MTHI);
  assign md_wr_lo      = w_idle_iss && (e_md_op == MD_MTLO);
  assign md_op         = w_idle_iss ? e_md_op : MD_NONE;
  assign illegal_issue = !w_idle && w_iss && (e_md_op != MD_NONE);
  assign busy          = !w_idle || md_start;
  assign stall_d       = d_uses_md && busy;
  assign md_done       = !w_idle && w_done;
  assign stall_cnt     = r_stall_cnt;

  assign w_load_val = md_is_div(e_md_op) ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);

  md_lat_cnt #(
    .CNT_W (CNT_W)
  ) u_lat_cnt (
    .clk        (clk),
    .reset      (reset),
    .i_load     (md_start),
    .i_load_val (w_load_val),
    .o_done     (w_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (md_start) r_state <= ST_BUSY;
        ST_BUSY: if (w_done)   r_state <= ST_IDLE;
        default:               r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= STALL_CNT_RST;
    end else if (stall_d && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_md_sched.sv
// Self-checking bench for md_sched: directed scenarios plus random traffic,
// compared cycle by cycle against a busy-window reference model.
module tb_md_sched;
  import md_sched_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        e_valid = 1'b0;
  logic [2:0]  e_md_op = 3'd0;
  logic        flush = 1'b0;
  logic        d_uses_md = 1'b0;

  logic        md_start, md_wr_hi, md_wr_lo, busy, stall_d, md_done, illegal_issue;
  logic [2:0]  md_op;
  logic [31:0] stall_cnt;
  logic        b_md_start, b_md_wr_hi, b_md_wr_lo, b_busy, b_stall_d, b_md_done, b_illegal;
  logic [2:0]  b_md_op;
  logic [31:0] b_stall_cnt;

  always #5 clk = ~clk;

  md_sched dut (
    .clk(clk), .reset(reset), .e_valid(e_valid), .e_md_op(e_md_op), .flush(flush),
    .d_uses_md(d_uses_md), .md_start(md_start), .md_op(md_op), .md_wr_hi(md_wr_hi),
    .md_wr_lo(md_wr_lo), .busy(busy), .stall_d(stall_d), .md_done(md_done),
    .illegal_issue(illegal_issue), .stall_cnt(stall_cnt)
  );

  // Second instance reset close to the top of the counter range for saturation.
  md_sched #(
    .STALL_CNT_RST (32'hFFFF_FFFE)
  ) dut_sat (
    .clk(clk), .reset(reset), .e_valid(e_valid), .e_md_op(e_md_op), .flush(flush),
    .d_uses_md(d_uses_md), .md_start(b_md_start), .md_op(b_md_op), .md_wr_hi(b_md_wr_hi),
    .md_wr_lo(b_md_wr_lo), .busy(b_busy), .stall_d(b_stall_d), .md_done(b_md_done),
    .illegal_issue(b_illegal), .stall_cnt(b_stall_cnt)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: the unit is occupied for every cycle strictly before free_at.
  longint      cyc = 0;
  longint      free_at = 0;
  logic [31:0] m_cnt_a = '0;
  logic [31:0] m_cnt_b = 32'hFFFF_FFFE;
  logic        armed = 1'b0;

  task automatic step(input logic v, input logic f, input logic [2:0] op,
                      input logic du, input logic rst);
    logic in_busy, iss, m_start, m_whi, m_wlo, m_busy, m_done, m_ill, m_stall;
    logic [2:0] m_op;
    int unsigned lat;
    e_valid = v; flush = f; e_md_op = op; d_uses_md = du; reset = rst;
    #2;
    in_busy = (cyc < free_at);
    iss     = v && !f;
    if (!in_busy) begin
      m_start = iss && (op inside {3'd1, 3'd2, 3'd3, 3'd4, 3'd5});
      m_whi   = iss && (op == 3'd6);
      m_wlo   = iss && (op == 3'd7);
      m_op    = iss ? op : 3'd0;
      m_busy  = m_start;
      m_done  = 1'b0;
      m_ill   = 1'b0;
    end else begin
      m_start = 1'b0; m_whi = 1'b0; m_wlo = 1'b0; m_op = 3'd0;
      m_busy  = 1'b1;
      m_done  = (cyc == free_at - 1);
      m_ill   = iss && (op != 3'd0);
    end
    m_stall = du && m_busy;
    if (armed) begin
      check("md_start", 32'(md_start), 32'(m_start));
      check("md_op", 32'(md_op), 32'(m_op));
      check("md_wr_hi", 32'(md_wr_hi), 32'(m_whi));
      check("md_wr_lo", 32'(md_wr_lo), 32'(m_wlo));
      check("busy", 32'(busy), 32'(m_busy));
      check("stall_d", 32'(stall_d), 32'(m_stall));
      check("md_done", 32'(md_done), 32'(m_done));
      check("illegal_issue", 32'(illegal_issue), 32'(m_ill));
      check("stall_cnt", stall_cnt, m_cnt_a);
      check("sat_stall_cnt", b_stall_cnt, m_cnt_b);
    end
    @(posedge clk);
    #1;
    if (rst) begin
      free_at = cyc + 1;
      m_cnt_a = '0;
      m_cnt_b = 32'hFFFF_FFFE;
      armed   = 1'b1;
    end else begin
      lat = (op == 3'd3 || op == 3'd4) ? 10 : 5;
      if (m_start) free_at = cyc + 1 + lat;
      if (m_stall && m_cnt_a != 32'hFFFF_FFFF) m_cnt_a = m_cnt_a + 1;
      if (m_stall && m_cnt_b != 32'hFFFF_FFFF) m_cnt_b = m_cnt_b + 1;
    end
    cyc++;
  endtask

  task automatic idle(input int unsigned n, input logic du);
    for (int unsigned i = 0; i < n; i++) step(1'b0, 1'b0, 3'd0, du, 1'b0);
  endtask

  initial begin
    logic [31:0] base;
    step(1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
    check("rst_stall_cnt", stall_cnt, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_md_op", 32'(md_op), 32'(MD_NONE));

    // Multiply followed by a dependent MFLO every cycle.
    step(1'b1, 1'b0, MD_MULT, 1'b1, 1'b0);
    idle(6, 1'b1);
    check("mult_stall_total", stall_cnt, 32'd6);

    // Divide followed by a dependent MFHI.
    base = stall_cnt;
    step(1'b1, 1'b0, MD_DIVU, 1'b1, 1'b0);
    idle(11, 1'b1);
    check("div_stall_total", stall_cnt - base, 32'd11);

    // Flushed divide must not issue; the next multiply does.
    step(1'b1, 1'b1, MD_DIV, 1'b0, 1'b0);
    step(1'b1, 1'b0, MD_MULT, 1'b0, 1'b0);
    idle(6, 1'b0);

    // MTHI while idle, then MTLO while busy.
    step(1'b1, 1'b0, MD_MTHI, 1'b1, 1'b0);
    step(1'b1, 1'b0, MD_MULTU, 1'b0, 1'b0);
    step(1'b1, 1'b0, MD_MTLO, 1'b0, 1'b0);
    idle(5, 1'b0);

    // Reset mid-multiply, then back-to-back MULT/MADD with stalls.
    step(1'b1, 1'b0, MD_MULT, 1'b1, 1'b0);
    idle(2, 1'b1);
    step(1'b0, 1'b0, 3'd0, 1'b1, 1'b1);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_cnt", stall_cnt, 32'd0);
    step(1'b1, 1'b0, MD_MULT, 1'b1, 1'b0);
    idle(5, 1'b1);
    step(1'b1, 1'b0, MD_MADD, 1'b1, 1'b0);
    idle(6, 1'b1);
    check("sat_hold", b_stall_cnt, 32'hFFFF_FFFF);

    // Random traffic.
    for (int unsigned i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
           ($urandom_range(0, 9) < 2) ? 1'b1 : 1'b0,
           3'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
